// File: rtl/cpu_boot_ctrl.sv
// Boot/run controller for the single-cycle MIPS core: streams image words into the
// memory write ports, releases the core from reset, and ends the run on halt or cycle budget.
module cpu_boot_ctrl #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned NUM_MEM    = 3,
  parameter int unsigned SEL_W      = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1,
  parameter int unsigned MAX_CYCLES = 200,
  parameter int unsigned HALT_REP   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic [SEL_W-1:0]   ld_sel,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               ld_last,
  input  logic               start,
  input  logic               clear,
  output logic [NUM_MEM-1:0] mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  output logic               cpu_rst_n,
  input  logic [DATA_W-1:0]  cpu_pc,
  output logic [31:0]        run_cycles,
  output logic               halted,
  output logic               timeout,
  output logic               load_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned REP_W = $clog2(HALT_REP + 1);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DONE} state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   addr_cnt_q [NUM_MEM];
  logic [NUM_MEM-1:0] mem_we_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [DATA_W-1:0]  mem_wdata_q;
  logic [DATA_W-1:0]  prev_pc_q;
  logic [REP_W-1:0]   rep_q;
  logic [31:0]        run_cycles_q;
  logic               halted_q;
  logic               timeout_q;
  logic               load_err_q;

  logic               hs;
  logic               sel_ok;
  logic [CNT_W-1:0]   cur_cnt;
  logic               bad_word;
  logic               pc_same;
  logic [31:0]        run_next;
  logic               halt_hit;
  logic               to_hit;

  // Handshake decode, stall detection and budget check
  always_comb begin
    hs       = ld_valid & (state_q == ST_LOAD);
    sel_ok   = 32'(ld_sel) < NUM_MEM;
    cur_cnt  = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      if (ld_sel == SEL_W'(i)) cur_cnt = addr_cnt_q[i];
    end
    bad_word = hs & (~sel_ok | cur_cnt[ADDR_W]);
    pc_same  = (cpu_pc == prev_pc_q);
    run_next = run_cycles_q + 32'd1;
    halt_hit = (state_q == ST_RUN) & pc_same & (rep_q == REP_W'(HALT_REP - 1));
    to_hit   = (state_q == ST_RUN) & (run_next == 32'(MAX_CYCLES));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_LOAD;
      for (int i = 0; i < NUM_MEM; i++) addr_cnt_q[i] <= '0;
      mem_we_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      prev_pc_q    <= '0;
      rep_q        <= '0;
      run_cycles_q <= '0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      mem_we_q  <= '0;
      prev_pc_q <= cpu_pc;
      case (state_q)
        ST_LOAD: begin
          // Accepted words are written one cycle later; an overflowed channel only records the error
          for (int i = 0; i < NUM_MEM; i++) begin
            if (hs && ld_sel == SEL_W'(i)) begin
              if (!addr_cnt_q[i][ADDR_W]) begin
                mem_we_q[i] <= 1'b1;
                mem_addr_q  <= addr_cnt_q[i][ADDR_W-1:0];
                mem_wdata_q <= ld_data;
                addr_cnt_q[i] <= ld_last ? '0 : addr_cnt_q[i] + CNT_W'(1);
              end else if (ld_last) begin
                addr_cnt_q[i] <= '0;
              end
            end
          end
          if (bad_word) load_err_q <= 1'b1;
          if (clear) begin
            load_err_q <= 1'b0;
            for (int i = 0; i < NUM_MEM; i++) addr_cnt_q[i] <= '0;
          end
          if (start) begin
            state_q <= ST_RUN;
            rep_q   <= '0;
          end
        end
        ST_RUN: begin
          run_cycles_q <= run_next;
          rep_q        <= pc_same ? rep_q + REP_W'(1) : '0;
          if (halt_hit) begin
            halted_q <= 1'b1;
            state_q  <= ST_DONE;
          end else if (to_hit) begin
            timeout_q <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (clear) begin
            state_q      <= ST_LOAD;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            load_err_q   <= 1'b0;
            run_cycles_q <= '0;
            for (int i = 0; i < NUM_MEM; i++) addr_cnt_q[i] <= '0;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  // Core reset follows rst_n immediately so an external reset freezes the CPU at once
  assign cpu_rst_n  = rst_n & (state_q == ST_RUN);
  assign ld_ready   = (state_q == ST_LOAD);
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign run_cycles = run_cycles_q;
  assign halted     = halted_q;
  assign timeout    = timeout_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// Randomised bench for cpu_boot_ctrl against a cycle-level behavioural model.
module tb_cpu_boot_ctrl;

  localparam int unsigned MAX_CYC = 200;
  localparam int unsigned REP     = 4;
  localparam int unsigned DEPTH   = 256;

  logic        clk, rst_n;
  logic        ld_valid, ld_ready, ld_last, start, clear;
  logic [1:0]  ld_sel;
  logic [31:0] ld_data, cpu_pc, mem_wdata, run_cycles;
  logic [2:0]  mem_we;
  logic [7:0]  mem_addr;
  logic        cpu_rst_n, halted, timeout, load_err;

  cpu_boot_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_data(ld_data), .ld_last(ld_last), .start(start), .clear(clear), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_rst_n(cpu_rst_n), .cpu_pc(cpu_pc),
    .run_cycles(run_cycles), .halted(halted), .timeout(timeout), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: mode 0=loading, 1=running, 2=finished
  int          m_mode;
  int unsigned m_cnt [3];
  bit          m_err, m_halt, m_to;
  int unsigned m_cycles;
  logic [2:0]  m_we;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic [31:0] hist [$];

  task automatic model_reset();
    m_mode = 0; m_err = 0; m_halt = 0; m_to = 0; m_cycles = 0;
    m_we = '0; m_addr = '0; m_wdata = '0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    hist.delete();
  endtask

  function automatic bit stalled();
    int n = hist.size();
    if (n < int'(REP) + 1) return 1'b0;
    for (int k = n - int'(REP) - 1; k < n; k++)
      if (hist[k] != hist[n-1]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    m_we = '0;
    case (m_mode)
      0: begin
        if (ld_valid) begin
          if (ld_sel >= 2'd3) m_err = 1;
          else if (m_cnt[ld_sel] >= DEPTH) begin
            m_err = 1;
            if (ld_last) m_cnt[ld_sel] = 0;
          end else begin
            m_we    = 3'(1 << ld_sel);
            m_addr  = 8'(m_cnt[ld_sel]);
            m_wdata = ld_data;
            m_cnt[ld_sel] = ld_last ? 0 : m_cnt[ld_sel] + 1;
          end
        end
        if (clear) begin
          m_err = 0;
          for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end
        if (start) begin
          m_mode = 1;
          hist.delete();
          hist.push_back(cpu_pc);
        end
      end
      1: begin
        m_cycles++;
        hist.push_back(cpu_pc);
        if (stalled()) begin m_halt = 1; m_mode = 2; end
        else if (m_cycles == MAX_CYC) begin m_to = 1; m_mode = 2; end
      end
      default: begin
        if (clear) begin
          m_mode = 0; m_halt = 0; m_to = 0; m_err = 0; m_cycles = 0;
          for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        end
      end
    endcase
  endtask

  task automatic check_all();
    check_val("ld_ready",   32'(ld_ready),  32'(m_mode == 0));
    check_val("cpu_rst_n",  32'(cpu_rst_n), 32'(m_mode == 1 && rst_n));
    check_val("mem_we",     32'(mem_we),    32'(m_we));
    check_val("mem_addr",   32'(mem_addr),  32'(m_addr));
    check_val("mem_wdata",  mem_wdata,      m_wdata);
    check_val("run_cycles", run_cycles,     m_cycles);
    check_val("halted",     32'(halted),    32'(m_halt));
    check_val("timeout",    32'(timeout),   32'(m_to));
    check_val("load_err",   32'(load_err),  32'(m_err));
  endtask

  // Drive one cycle of inputs, advance the model, then check after the edge
  task automatic cycle(input bit v, input logic [1:0] sel, input logic [31:0] d, input bit last,
                       input bit st, input bit clr, input logic [31:0] pc);
    ld_valid = v; ld_sel = sel; ld_data = d; ld_last = last;
    start = st; clear = clr; cpu_pc = pc;
    model_step();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic idle(input bit st, input bit clr, input logic [31:0] pc);
    cycle(1'b0, 2'd0, 32'h0, 1'b0, st, clr, pc);
  endtask

  task automatic word(input logic [1:0] sel, input logic [31:0] d, input bit last);
    cycle(1'b1, sel, d, last, 1'b0, 1'b0, 32'h0);
  endtask

  logic [31:0] pc_v;

  initial begin
    rst_n = 1'b0; ld_valid = 0; ld_sel = 0; ld_data = 0; ld_last = 0;
    start = 0; clear = 0; cpu_pc = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // Sequential fill of channel 0, wrap via ld_last on channel 2, out-of-range select
    word(2'd0, 32'h11, 0); word(2'd0, 32'h22, 0); word(2'd0, 32'h33, 0);
    word(2'd2, 32'hA, 0);  word(2'd2, 32'hB, 1);  word(2'd2, 32'hC, 0);
    check_val("wrap_addr", 32'(mem_addr), 32'h0);
    word(2'd3, 32'hDEAD, 0);
    idle(0, 0, 0);
    check_val("sel_err", 32'(load_err), 32'h1);
    idle(0, 1, 0);

    // Channel 1 overflow: depth+1 words without ld_last
    for (int i = 0; i <= int'(DEPTH); i++) word(2'd1, 32'(i) ^ 32'h5A5A0000, 0);
    idle(0, 0, 0);
    check_val("ovf_err", 32'(load_err), 32'h1);
    idle(0, 1, 0);
    check_val("ovf_clr", 32'(load_err), 32'h0);

    // Random load traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 9) == 0, 1'b0, $urandom_range(0, 49) == 0, 32'h0);

    // Run ending in halt: pc 0 while loading, then 4, 8, 12 held
    idle(1, 0, 0);
    idle(0, 0, 4); idle(0, 0, 8);
    for (int i = 0; i < 20 && m_mode == 1; i++) idle(0, 0, 12);
    check_val("halt_cycles", run_cycles, 32'd7);
    check_val("halt_flag", 32'(halted), 32'h1);
    idle(1, 0, 12);
    idle(0, 1, 12);

    // Run ending in timeout with an ever-changing pc
    idle(1, 0, 0);
    pc_v = 0;
    for (int i = 0; i < 300 && m_mode == 1; i++) begin pc_v += 4; idle(0, 0, pc_v); end
    check_val("to_cycles", run_cycles, 32'(MAX_CYC));
    check_val("to_flag", 32'(timeout), 32'h1);
    idle(0, 1, pc_v);
    check_val("to_clr", 32'(timeout), 32'h0);

    // Halt and budget coincide on the last cycle: halt takes precedence
    cycle(1'b1, 2'd1, 32'h77, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 1; i <= 300 && m_mode == 1; i++) idle(0, 0, 32'(4 * ((i < 196) ? i : 196)));
    check_val("tie_halt", 32'(halted), 32'h1);
    check_val("tie_to", 32'(timeout), 32'h0);
    idle(0, 1, 0);

    // Random runs with noise on the load and control inputs
    for (int r = 0; r < 8; r++) begin
      cycle($urandom_range(0, 1), 2'($urandom_range(0, 2)), $urandom, 1'b0, 1'b1, 1'b0, pc_v);
      for (int i = 0; i < 300 && m_mode == 1; i++) begin
        if ($urandom_range(0, 9) >= 4) pc_v += 4;
        cycle($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, $urandom_range(0, 1),
              $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, pc_v);
      end
      for (int i = 0; i < 3; i++)
        cycle($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom, 1'b0,
              $urandom_range(0, 1), 1'b0, pc_v);
      idle(0, 1, pc_v);
      for (int i = 0; i < 20; i++)
        cycle($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 5) == 0, 1'b0, 1'b0, 32'h0);
    end

    // Asynchronous reset in RUN cycle 50
    idle(1, 0, 0);
    pc_v = 0;
    for (int i = 0; i < 49; i++) begin pc_v += 4; idle(0, 0, pc_v); end
    check_val("pre_rst_cyc", run_cycles, 32'd49);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("async_cpu_rst", 32'(cpu_rst_n), 32'h0);
    check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
    word(2'd0, 32'hCAFE, 0);
    check_val("post_rst_addr", 32'(mem_addr), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
